note_seq_arbiter: RTL and testbench
===================================

NOTE_SEQ_ARBITER -- requirements
Module: note_seq_arbiter

Interface
REQ-001 The block SHALL use reset rst, asynchronous, active-high, and clock clk.
REQ-002 The block SHALL have parameter BEAT_CYC, default 25000000, giving the clk cycles per beat.
REQ-003 The block SHALL have parameter GAP_CYC, default 1000000, giving the silent clk cycles between melody notes.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have port play, input, 1 bit: single-cycle melody start pulse.
REQ-007 The block SHALL have port stop, input, 1 bit: single-cycle melody abort pulse.
REQ-008 The block SHALL have port key_valid, input, 1 bit: a keyboard note is held.
REQ-009 The block SHALL have port key_idx, input, 4 bits: keyboard note index 0-15.
REQ-010 The block SHALL have port note_div, output, 22 bits: divider value sent to the note generator, where 0 means silence.
REQ-011 The block SHALL have port note_idx, output, 4 bits: index currently sounding, where 15 means rest.
REQ-012 The block SHALL have port src, output, 1 bit: output owner, 0 for the melody and 1 for the keyboard.
REQ-013 The block SHALL have port busy, output, 1 bit: the melody sequencer is not IDLE.

Function
REQ-014 The block SHALL map each note index to a divider as follows: 0:227273, 1:204082, 2:191571, 3:170648, 4:151515, 5:143266, 6:127551, 7:113636, 8:101215, 9:95420, 10:85034, 11:75758, 12:71633, 13:63776, and 14 or 15 to 0.
REQ-015 The block SHALL contain an internal 16-step melody ROM in which each entry holds {idx[3:0], beats[1:0]}.
- Steps 0-13 have idx equal to the step number.
- Steps 14 and 15 have idx 15.
- Step 0 has beats 2; all other steps have beats 1.
- A beats value of 0 SHALL mean 4.
REQ-016 The block SHALL implement the FSM states IDLE, NOTE, GAP and HOLD.
REQ-017 In IDLE, a play pulse SHALL move the FSM to NOTE with step 0 and the cycle counter set to 0.
REQ-018 In NOTE, the block SHALL output the ROM idx for beats×BEAT_CYC cycles and then go to GAP.
REQ-019 In GAP, the block SHALL output note_div=0 and note_idx=15 for GAP_CYC cycles, then increment step and return to NOTE.
REQ-020 After the GAP of step 15, the FSM SHALL go to IDLE, unless SEQ_LOOP_EN is defined.
REQ-021 While key_valid is 1 in NOTE or GAP, the FSM SHALL be in HOLD.
- step, counter and the return state SHALL be frozen.
- note_div and note_idx SHALL follow key_idx.
- src SHALL be 1.
REQ-022 When key_valid falls, the FSM SHALL resume the frozen state and counter on the next cycle.
REQ-023 In IDLE, key_valid=1 SHALL drive the key note with src=1 and busy=0; otherwise the block SHALL output note_div=0 and note_idx=15.
REQ-024 A stop pulse in any state SHALL force IDLE with step=0 and counter=0 on the next edge.
REQ-025 If stop and play are asserted in the same cycle, stop SHALL win.
REQ-026 A play pulse while busy=1, including in HOLD, SHALL be ignored.
REQ-027 All outputs SHALL be registered, so a play sampled at edge N produces busy=1 and note_div=227273 after edge N+1.
REQ-028 The counter SHALL be 26 bits wide and SHALL saturate at no value; it is cleared on every state transition other than HOLD entry and exit.

Reset
REQ-029 While rst=1, the block SHALL hold state=IDLE, step=0, counter=0, note_div=0, note_idx=15, src=0 and busy=0.
REQ-030 Reset asserted mid-note SHALL silence note_div immediately, asynchronously; the melody SHALL NOT resume after reset is released.

Configuration
REQ-031 If SEQ_LOOP_EN is defined, step 15 SHALL wrap to step 0 in NOTE with busy held at 1 until stop is asserted.
- Without SEQ_LOOP_EN, the FSM SHALL go to IDLE after step 15 and busy SHALL fall.

Verification (BEAT_CYC=4, GAP_CYC=2)
REQ-032 The bench SHALL cover play-to-completion: play pulse -> step 0 at 227273 for 8 cycles, gap of 2 cycles at 0, step 1 at 204082 for 4 cycles, ..., then busy=0 after step 15 (without SEQ_LOOP_EN).
REQ-033 The bench SHALL cover key override mid-note: key_valid=1 with key_idx=4 during step 2 after 1 cycle -> note_div=151515 and src=1; when key_valid falls, 191571 resumes for the remaining 3 cycles.
REQ-034 The bench SHALL cover simultaneous stop and play in NOTE -> IDLE, note_div=0 and busy=0 on the next edge.
REQ-035 The bench SHALL cover reset mid-GAP: rst pulse -> all outputs at their reset values with no restart afterward.
REQ-036 The bench SHALL cover looping with SEQ_LOOP_EN defined: after step 15's GAP -> note_div=227273 with busy remaining 1.
REQ-037 The bench SHALL cover IDLE keyboard use: key_valid=1 with key_idx=13 -> note_div=63776, src=1 and busy=0.

Source files
------------

// File: rtl/note_seq_arbiter.sv
// note_seq_arbiter: 16-step melody sequencer whose output can be taken over by a keyboard.
// Outputs are registered from the current state, so they trail the FSM by one edge.
// A stop pulse is the exception: it silences the outputs on the same edge that it forces IDLE.
// Optional build macro: SEQ_LOOP_EN. When defined, the melody wraps from step 15 to step 0.
module note_seq_arbiter #(
    parameter int unsigned BEAT_CYC = 25000000,
    parameter int unsigned GAP_CYC  = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play,
    input  logic        stop,
    input  logic        key_valid,
    input  logic [3:0]  key_idx,
    output logic [21:0] note_div,
    output logic [3:0]  note_idx,
    output logic        src,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StNote, StGap, StHold} state_e;

    localparam logic [3:0]  RestIdx = 4'd15;
    localparam logic [31:0] GapLast = 32'(GAP_CYC) - 32'd1;

    state_e      state_q, state_d;
    state_e      ret_q, ret_d;
    state_e      view;
    logic [3:0]  step_q, step_d;
    logic [25:0] cnt_q, cnt_d;

    logic [21:0] note_div_q, note_div_d;
    logic [3:0]  note_idx_q, note_idx_d;
    logic        src_q, src_d;
    logic        busy_q, busy_d;

    logic [5:0]  rom_cur;
    logic [3:0]  rom_idx;
    logic [2:0]  beats_n;
    logic [31:0] note_last;
    logic        note_done;
    logic        gap_done;

    // Note index to divider; indices 14 and 15 are silent.
    function automatic logic [21:0] div_of(input logic [3:0] idx);
        logic [21:0] d;
        case (idx)
            4'd0:    d = 22'd227273;
            4'd1:    d = 22'd204082;
            4'd2:    d = 22'd191571;
            4'd3:    d = 22'd170648;
            4'd4:    d = 22'd151515;
            4'd5:    d = 22'd143266;
            4'd6:    d = 22'd127551;
            4'd7:    d = 22'd113636;
            4'd8:    d = 22'd101215;
            4'd9:    d = 22'd95420;
            4'd10:   d = 22'd85034;
            4'd11:   d = 22'd75758;
            4'd12:   d = 22'd71633;
            4'd13:   d = 22'd63776;
            default: d = 22'd0;
        endcase
        return d;
    endfunction

    // Melody ROM entry {idx, beats}; a beats field of 0 would mean four beats.
    function automatic logic [5:0] rom_entry(input logic [3:0] step);
        logic [5:0] e;
        case (step)
            4'd0:    e = {4'd0,  2'd2};
            4'd1:    e = {4'd1,  2'd1};
            4'd2:    e = {4'd2,  2'd1};
            4'd3:    e = {4'd3,  2'd1};
            4'd4:    e = {4'd4,  2'd1};
            4'd5:    e = {4'd5,  2'd1};
            4'd6:    e = {4'd6,  2'd1};
            4'd7:    e = {4'd7,  2'd1};
            4'd8:    e = {4'd8,  2'd1};
            4'd9:    e = {4'd9,  2'd1};
            4'd10:   e = {4'd10, 2'd1};
            4'd11:   e = {4'd11, 2'd1};
            4'd12:   e = {4'd12, 2'd1};
            4'd13:   e = {4'd13, 2'd1};
            default: e = {4'd15, 2'd1};
        endcase
        return e;
    endfunction

    // Current step's note and the terminal counts of the NOTE and GAP phases.
    always_comb begin
        rom_cur   = rom_entry(step_q);
        rom_idx   = rom_cur[5:2];
        beats_n   = (rom_cur[1:0] == 2'd0) ? 3'd4 : {1'b0, rom_cur[1:0]};
        note_last = 32'(beats_n) * BEAT_CYC - 32'd1;
        note_done = ({6'd0, cnt_q} == note_last);
        gap_done  = ({6'd0, cnt_q} == GapLast);
    end

    // Sequencer next state: stop beats everything, then keyboard hold, then timing.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        if (stop) begin
            state_d = StIdle;
            step_d  = 4'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (play) begin
                        state_d = StNote;
                        step_d  = 4'd0;
                        cnt_d   = '0;
                    end
                end
                StNote: begin
                    if (key_valid) begin
                        // Freeze step and counter; remember where to come back to.
                        state_d = StHold;
                        ret_d   = StNote;
                    end else if (note_done) begin
                        state_d = StGap;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 26'd1;
                    end
                end
                StGap: begin
                    if (key_valid) begin
                        state_d = StHold;
                        ret_d   = StGap;
                    end else if (gap_done) begin
                        cnt_d = '0;
                        if (step_q == 4'd15) begin
                            step_d  = 4'd0;
`ifdef SEQ_LOOP_EN
                            state_d = StNote;
`else
                            state_d = StIdle;
`endif
                        end else begin
                            step_d  = step_q + 4'd1;
                            state_d = StNote;
                        end
                    end else begin
                        cnt_d = cnt_q + 26'd1;
                    end
                end
                StHold: begin
                    if (!key_valid) begin
                        state_d = ret_q;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output next values; a stop pulse is viewed as IDLE so silence lands on the same edge.
    always_comb begin
        view       = stop ? StIdle : state_q;
        note_idx_d = RestIdx;
        src_d      = 1'b0;
        busy_d     = (view != StIdle);
        case (view)
            StIdle: begin
                if (key_valid) begin
                    note_idx_d = key_idx;
                    src_d      = 1'b1;
                end
            end
            StNote: note_idx_d = rom_idx;
            StHold: begin
                if (key_valid) begin
                    note_idx_d = key_idx;
                    src_d      = 1'b1;
                end else if (ret_q == StNote) begin
                    note_idx_d = rom_idx;
                end
            end
            default: ;
        endcase
        note_div_d = div_of(note_idx_d);
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ret_q   <= StNote;
            step_q  <= 4'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output registers; reset silences the generator immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            note_div_q <= '0;
            note_idx_q <= RestIdx;
            src_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            note_div_q <= note_div_d;
            note_idx_q <= note_idx_d;
            src_q      <= src_d;
            busy_q     <= busy_d;
        end
    end

    assign note_div = note_div_q;
    assign note_idx = note_idx_q;
    assign src      = src_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_note_seq_arbiter.sv
// Bench for note_seq_arbiter: directed scenarios plus random play/stop/key traffic,
// checked per cycle against a phase/remaining-cycles reference model through a queue.
module tb_note_seq_arbiter;

    localparam int BEAT = 4;
    localparam int GAP  = 2;

    logic        clk;
    logic        rst;
    logic        play;
    logic        stop;
    logic        key_valid;
    logic [3:0]  key_idx;
    logic [21:0] note_div;
    logic [3:0]  note_idx;
    logic        src;
    logic        busy;

    note_seq_arbiter #(
        .BEAT_CYC(BEAT),
        .GAP_CYC (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .play     (play),
        .stop     (stop),
        .key_valid(key_valid),
        .key_idx  (key_idx),
        .note_div (note_div),
        .note_idx (note_idx),
        .src      (src),
        .busy     (busy)
    );

    int unsigned div_tab [16] = '{227273, 204082, 191571, 170648, 151515, 143266, 127551,
                                  113636, 101215, 95420, 85034, 75758, 71633, 63776, 0, 0};

    // Reference model: is a melody active, is it held by the keyboard, which step,
    // note or gap phase, and how many un-held cycles remain in that phase.
    bit m_play;
    bit m_hold;
    bit m_gap;
    int m_step;
    int m_left;

    logic [27:0] exp_q [$];
    int n_cmp;
    int n_bad;

    function automatic int mel_idx(input int s);
        return (s < 14) ? s : 15;
    endfunction

    function automatic int mel_dur(input int s);
        return ((s == 0) ? 2 : 1) * BEAT;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // One clock: drive inputs at the falling edge, queue the expected registered outputs
    // for the coming rising edge, then advance the model.
    task automatic step_cycle(input logic p, input logic s, input logic kv,
                              input logic [3:0] ki, input logic r);
        logic [21:0] ed;
        logic [3:0]  ei;
        logic        es;
        logic        eb;
        @(negedge clk);
        play      = p;
        stop      = s;
        key_valid = kv;
        key_idx   = ki;
        rst       = r;
        ed = '0;
        ei = 4'd15;
        es = 1'b0;
        eb = 1'b0;
        if (!r) begin
            if (s || !m_play) begin
                if (kv) begin
                    ei = ki;
                    es = 1'b1;
                end
            end else begin
                eb = 1'b1;
                if (m_hold && kv) begin
                    ei = ki;
                    es = 1'b1;
                end else if (!m_gap) begin
                    ei = 4'(mel_idx(m_step));
                end
            end
            ed = 22'(div_tab[ei]);
        end
        exp_q.push_back({ed, ei, es, eb});

        if (r || s) begin
            m_play = 0;
            m_hold = 0;
        end else if (!m_play) begin
            if (p) begin
                m_play = 1;
                m_hold = 0;
                m_gap  = 0;
                m_step = 0;
                m_left = mel_dur(0);
            end
        end else if (m_hold) begin
            if (!kv) m_hold = 0;
        end else if (kv) begin
            m_hold = 1;
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (!m_gap) begin
                    m_gap  = 1;
                    m_left = GAP;
                end else if (m_step == 15) begin
`ifdef SEQ_LOOP_EN
                    m_step = 0;
                    m_gap  = 0;
                    m_left = mel_dur(0);
`else
                    m_play = 0;
`endif
                end else begin
                    m_step++;
                    m_gap  = 0;
                    m_left = mel_dur(m_step);
                end
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step_cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: the outputs are presented every cycle; compare each against the queue.
    initial begin
        logic [27:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({note_div, note_idx, src, busy} !== e) begin
                    n_bad++;
                    $display("FAIL scoreboard t=%0t: got div=%0d idx=%0d src=%0d busy=%0d, want div=%0d idx=%0d src=%0d busy=%0d",
                             $time, note_div, note_idx, src, busy,
                             e[27:6], e[5:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int  guard;
        bit  seen15;
        logic       rk;
        logic [3:0] rki;
        n_cmp = 0;
        n_bad = 0;
        m_play = 0;
        m_hold = 0;
        m_gap  = 0;
        m_step = 0;
        m_left = 0;
        rst = 1'b1;
        play = 1'b0;
        stop = 1'b0;
        key_valid = 1'b0;
        key_idx = 4'd0;

        // Reset state.
        step_cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        step_cycle(1'b1, 1'b0, 1'b1, 4'd3, 1'b1);
        chk("reset_div", note_div, 0);
        chk("reset_idx", note_idx, 15);
        chk("reset_src", src, 0);
        chk("reset_busy", busy, 0);
        idle_cycles(2);

        // Play to completion.
        step_cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("play_no_early_busy", busy, 0);
        idle_cycles(1);
        chk("play_step0_div", note_div, 227273);
        chk("play_step0_busy", busy, 1);
        idle_cycles(8);
        chk("play_step0_gap", note_div, 0);
        idle_cycles(2);
        chk("play_step1_div", note_div, 204082);
`ifndef SEQ_LOOP_EN
        guard = 0;
        while (m_play && guard < 200) begin
            idle_cycles(1);
            guard++;
        end
        chk("play_finish_bound", guard < 200, 1);
        idle_cycles(1);
        chk("play_done_busy", busy, 0);
        chk("play_done_div", note_div, 0);
`else
        // Looping: after step 15's gap the melody restarts at step 0.
        seen15 = 0;
        guard  = 0;
        while (!(seen15 && m_step == 0) && guard < 200) begin
            if (m_step == 15) seen15 = 1;
            idle_cycles(1);
            guard++;
        end
        chk("loop_wrap_bound", guard < 200, 1);
        idle_cycles(1);
        chk("loop_wrap_div", note_div, 227273);
        chk("loop_wrap_busy", busy, 1);
`endif
        step_cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        // Key override during step 2, one cycle into the note.
        step_cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        guard = 0;
        while (!(m_play && m_step == 2 && !m_gap && m_left == 3) && guard < 200) begin
            idle_cycles(1);
            guard++;
        end
        chk("hold_reach_bound", guard < 200, 1);
        step_cycle(1'b0, 1'b0, 1'b1, 4'd4, 1'b0);
        step_cycle(1'b1, 1'b0, 1'b1, 4'd4, 1'b0);
        chk("hold_key_div", note_div, 151515);
        chk("hold_key_src", src, 1);
        chk("hold_busy", busy, 1);
        step_cycle(1'b0, 1'b0, 1'b1, 4'd4, 1'b0);
        step_cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("hold_resume_div", note_div, 191571);
        chk("hold_resume_src", src, 0);
        idle_cycles(3);
        chk("hold_resume_last", note_div, 191571);
        idle_cycles(1);
        chk("hold_resume_gap", note_div, 0);
        step_cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        // Stop and play together while a note sounds.
        step_cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        idle_cycles(3);
        step_cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("stopplay_div", note_div, 0);
        chk("stopplay_busy", busy, 0);
        idle_cycles(3);
        chk("stopplay_stays_idle", busy, 0);

        // Reset in the middle of a gap.
        step_cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        guard = 0;
        while (!m_gap && guard < 50) begin
            idle_cycles(1);
            guard++;
        end
        chk("rstgap_reach_bound", guard < 50, 1);
        idle_cycles(1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstgap_async_div", note_div, 0);
        chk("rstgap_async_idx", note_idx, 15);
        chk("rstgap_async_busy", busy, 0);
        step_cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        idle_cycles(20);
        chk("rstgap_no_restart", busy, 0);

        // Keyboard while idle.
        step_cycle(1'b0, 1'b0, 1'b1, 4'd13, 1'b0);
        chk("idlekey_div", note_div, 63776);
        chk("idlekey_src", src, 1);
        chk("idlekey_busy", busy, 0);
        step_cycle(1'b0, 1'b0, 1'b0, 4'd13, 1'b0);
        chk("idlekey_release", note_div, 0);

        // Random traffic.
        rk  = 1'b0;
        rki = 4'd0;
        for (int i = 0; i < 3000; i++) begin
            if (rk) begin
                if ($urandom_range(0, 3) == 0) rk = 1'b0;
            end else if ($urandom_range(0, 11) == 0) begin
                rk = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) rki = 4'($urandom_range(0, 15));
            step_cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 79) == 0), rk, rki, 1'b0);
        end
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
